// File: rtl/ad_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : ad_trig_capture
// Brief    : Armed circular capture of one ADC channel with level-crossing
//            trigger, pre-trigger history and time-ordered record readout.
//            Optional force-trigger timeout under macro AD_TRIG_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ad_trig_capture #(
    parameter int DATA_W      = 14,
    parameter int DEPTH       = 1024,
    parameter int TIMEOUT_CYC = 65536,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] ad_data,
    input  logic              ad_of,
    input  logic              ad_vld,
    input  logic              arm,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] pre_len,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic              of_flag,
    output logic              trig_forced
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_one_a    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_one_p    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(DEPTH);

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wp, r_rp, r_pre_len, r_pre_cnt, r_rd_cnt;
    logic [ADDR_W:0]     r_post_rem;
    logic [DATA_W-1:0]   r_level, r_prev, r_rd_data;
    logic                r_rising, r_have_prev, r_of_flag, r_rd_vld, r_rd_last;

    logic                w_arm_ok, w_wr, w_cross, w_force, w_trig, w_rd, w_rd_last;
    logic [ADDR_W:0]     w_post_len;

    assign w_arm_ok   = (r_state == S_IDLE) && arm;
    assign w_wr       = ((r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST)) && ad_vld;
    // Crossing needs a previous captured sample; the first one after arm has none.
    assign w_cross    = r_have_prev && (r_rising ? ((r_prev < r_level) && (ad_data >= r_level))
                                                 : ((r_prev > r_level) && (ad_data <= r_level)));
    assign w_trig     = (r_state == S_WAIT) && ad_vld && (w_cross || w_force);
    assign w_rd       = (r_state == S_DONE) && rd_req;
    assign w_rd_last  = w_rd && (r_rd_cnt == c_last_idx);
    assign w_post_len = c_depth - {1'b0, r_pre_len};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (arm) w_state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
            S_PRE:  if (ad_vld && (r_pre_cnt == r_pre_len - c_one_a)) w_state_nxt = S_WAIT;
            S_WAIT: if (w_trig) w_state_nxt = (w_post_len == c_one_p) ? S_DONE : S_POST;
            S_POST: if (ad_vld && (r_post_rem == c_one_p)) w_state_nxt = S_DONE;
            S_DONE: if (w_rd_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_rp        <= '0;
            r_pre_len   <= '0;
            r_pre_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_post_rem  <= '0;
            r_level     <= '0;
            r_prev      <= '0;
            r_rd_data   <= '0;
            r_rising    <= 1'b0;
            r_have_prev <= 1'b0;
            r_of_flag   <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arm_ok) begin
                r_level     <= trig_level;
                r_rising    <= trig_rising;
                r_pre_len   <= pre_len;
                r_of_flag   <= 1'b0;
                r_have_prev <= 1'b0;
                r_pre_cnt   <= '0;
                r_rd_cnt    <= '0;
            end
            if (w_wr) begin
                r_wp        <= r_wp + c_one_a;
                r_prev      <= ad_data;
                r_have_prev <= 1'b1;
                if (ad_of) r_of_flag <= 1'b1;
            end
            if ((r_state == S_PRE) && ad_vld) r_pre_cnt <= r_pre_cnt + c_one_a;
            // Trigger sample is the first post write; readout starts pre_len back.
            if (w_trig) begin
                r_post_rem <= w_post_len - c_one_p;
                r_rp       <= r_wp - r_pre_len;
            end else if ((r_state == S_POST) && ad_vld) begin
                r_post_rem <= r_post_rem - c_one_p;
            end
            r_rd_vld  <= w_rd;
            r_rd_last <= w_rd_last;
            if (w_rd) begin
                r_rd_data <= r_mem[r_rp];
                r_rp      <= r_rp + c_one_a;
                r_rd_cnt  <= r_rd_cnt + c_one_a;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_wr) r_mem[r_wp] <= ad_data;
    end

`ifdef AD_TRIG_TIMEOUT_EN
    localparam int               c_to_w   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYC);
    localparam logic [c_to_w-1:0] c_to_one = c_to_w'(1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_trig_forced;

    // Held at zero outside WAIT_TRIG so every entry starts a fresh count.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_cnt      <= '0;
            r_trig_forced <= 1'b0;
        end else begin
            if (r_state != S_WAIT)      r_to_cnt <= '0;
            else if (r_to_cnt != c_to_max) r_to_cnt <= r_to_cnt + c_to_one;
            if (w_arm_ok)                r_trig_forced <= 1'b0;
            else if (w_trig && !w_cross) r_trig_forced <= 1'b1;
        end
    end

    assign w_force     = (r_to_cnt == c_to_max);
    assign trig_forced = r_trig_forced;
`else
    assign w_force     = 1'b0;
    assign trig_forced = 1'b0;
`endif

    assign rd_data = r_rd_data;
    assign rd_vld  = r_rd_vld;
    assign rd_last = r_rd_last;
    assign busy    = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    assign done    = (r_state == S_DONE);
    assign of_flag = r_of_flag;

endmodule
`default_nettype wire

// File: tb/tb_ad_trig_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad_trig_capture
// Brief    : Scoreboard bench for ad_trig_capture; records are predicted from
//            the captured sample list, readout compared by a monitor process.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad_trig_capture;

    localparam int DATA_W      = 14;
    localparam int DEPTH       = 16;
    localparam int TIMEOUT_CYC = 100;

    logic              sys_clk = 1'b0;
    logic              sys_rst_n;
    logic [DATA_W-1:0] ad_data;
    logic              ad_of, ad_vld, arm, trig_rising, rd_req;
    logic [DATA_W-1:0] trig_level;
    logic [3:0]        pre_len;
    logic [DATA_W-1:0] rd_data;
    logic              rd_vld, rd_last, busy, done, of_flag, trig_forced;

    ad_trig_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ad_data(ad_data), .ad_of(ad_of),
        .ad_vld(ad_vld), .arm(arm), .trig_level(trig_level), .trig_rising(trig_rising),
        .pre_len(pre_len), .rd_req(rd_req), .rd_data(rd_data), .rd_vld(rd_vld),
        .rd_last(rd_last), .busy(busy), .done(done), .of_flag(of_flag),
        .trig_forced(trig_forced)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [DATA_W-1:0] d; logic last; } exp_t;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Reference: first sample index that satisfies the crossing rule once past the
    // pre-trigger fill, given the whole stream written since arm.
    function automatic int find_trig(input int s[$], input int lvl, input bit rising, input int pre);
        for (int i = pre; i < s.size(); i++) begin
            int p, c;
            if (i == 0) continue;
            p = s[i-1] & 'h3FFF;
            c = s[i] & 'h3FFF;
            if (rising ? (p < lvl && c >= lvl) : (p > lvl && c <= lvl)) return i;
        end
        return -1;
    endfunction

    function automatic bit of_of(input int v);
        return ((v >> 14) & 1) != 0;
    endfunction

    task automatic gen_random(input int lvl, input bit rising, input int pre, input bit ofr, output int s[$]);
        int t;
        s = {};
        for (int i = 0; i < 40; i++)
            s.push_back(lvl - 64 + int'($urandom_range(0, 127)) +
                        ((ofr && $urandom_range(0, 15) == 0) ? 16384 : 0));
        if (find_trig(s, lvl, rising, pre) < 0) begin
            s.push_back(rising ? lvl - 1 : lvl + 1);
            s.push_back(lvl);
        end
        t = find_trig(s, lvl, rising, pre);
        while (s.size() < t + DEPTH - pre) s.push_back(lvl - 64 + int'($urandom_range(0, 127)));
    endtask

    task automatic do_arm(input int lvl, input bit rising, input int pre, input bit noise);
        arm = 1'b1; trig_level = DATA_W'(lvl); trig_rising = rising; pre_len = 4'(pre);
        ad_vld = noise; ad_data = DATA_W'($urandom); ad_of = noise;
        tick();
        arm = 1'b0; ad_vld = 1'b0; ad_of = 1'b0;
        check("busy_after_arm", busy, 1);
        check("of_cleared_at_arm", of_flag, 0);
        check("done_after_arm", done, 0);
    endtask

    task automatic do_read();
        for (int i = 0; i < DEPTH; i++) begin
            repeat ($urandom_range(0, 1)) begin rd_req = 1'b0; tick(); end
            rd_req = 1'b1;
            tick();
        end
        rd_req = 1'b0;
        check("done_drops_after_last_read", done, 0);
        repeat (3) tick();
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        ad_vld = 1'b0; rd_req = 1'b0; arm = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check("outputs_in_reset", {rd_data, rd_vld, rd_last, busy, done, of_flag, trig_forced}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
    endtask

    task automatic capture(input int lvl, input bit rising, input int pre, input int s[$],
                           input bit noise, input bit rst_post);
        int t, need;
        bit exp_of;
        t = find_trig(s, lvl, rising, pre);
        need = t + DEPTH - pre;
        exp_of = 1'b0;
        do_arm(lvl, rising, pre, noise);
        for (int k = 0; k < need; k++) begin
            repeat ($urandom_range(0, 2)) begin
                ad_vld = 1'b0;
                rd_req = noise && ($urandom_range(0, 1) == 1);
                arm = noise && ($urandom_range(0, 2) == 0);
                trig_level = DATA_W'($urandom); pre_len = 4'($urandom);
                tick();
            end
            ad_vld = 1'b1; ad_data = DATA_W'(s[k] & 'h3FFF); ad_of = of_of(s[k]);
            exp_of = exp_of | of_of(s[k]);
            tick();
            if (rst_post && k == t + 2) begin
                check("busy_in_post", busy, 1);
                check("of_before_reset", of_flag, exp_of);
                do_reset();
                return;
            end
        end
        ad_vld = 1'b0; ad_of = 1'b0; arm = 1'b0; rd_req = 1'b0;
        check("done_at_record_end", done, 1);
        check("busy_at_done", busy, 0);
        check("of_flag_at_done", of_flag, exp_of);
        check("trig_forced_natural", trig_forced, 0);
        repeat (3) begin ad_vld = 1'b1; ad_data = DATA_W'($urandom); tick(); end
        ad_vld = 1'b0;
        arm = 1'b1; pre_len = 4'($urandom); tick(); arm = 1'b0;
        check("done_holds_arm_ignored", done, 1);
        for (int i = 0; i < DEPTH; i++) begin
            exp_t e;
            e.d = DATA_W'(s[t - pre + i] & 'h3FFF);
            e.last = (i == DEPTH - 1);
            sb_q.push_back(e);
        end
        do_read();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (rd_vld) begin
                if (sb_q.size() == 0) check("rd_vld_unexpected", rd_vld, 0);
                else begin
                    e = sb_q.pop_front();
                    check("rd_data", rd_data, e.d);
                    check("rd_last", rd_last, e.last);
                end
            end else if (rd_last) begin
                check("rd_last_without_vld", rd_last, 0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int s[$];
        int lvl, pre;
        bit rising;
        real x;
        sys_rst_n = 1'b0; ad_data = '0; ad_of = 1'b0; ad_vld = 1'b0; arm = 1'b0;
        trig_level = '0; trig_rising = 1'b0; pre_len = '0; rd_req = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_state", {rd_data, rd_vld, rd_last, busy, done, of_flag, trig_forced}, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();

        // Ramp through mid-scale after six low pre samples.
        s = {};
        for (int i = 0; i < 6; i++) s.push_back('h1F00 + i);
        s.push_back('h1FF0); s.push_back('h1FF8);
        for (int j = 0; j < 22; j++) s.push_back('h2008 + 8 * j);
        capture('h2000, 1'b1, 4, s, 1'b0, 1'b0);

        // Full-scale sine, falling trigger.
        s = {};
        for (int k = 0; k < 40; k++) begin
            x = 8192.0 + 8191.0 * $sin(2.0 * 3.14159265358979 * k / 13.0);
            s.push_back($rtoi(x + 0.5));
        end
        capture('h2000, 1'b0, 4, s, 1'b0, 1'b0);

        // No history, trigger on the second sample.
        s = {'h1000, 'h3000};
        for (int i = 0; i < 20; i++) s.push_back(int'($urandom_range(0, 'h3FFF)));
        capture('h2000, 1'b1, 0, s, 1'b0, 1'b0);

        // Over-range during POST with ignored arm/rd_req noise, then of_flag cleared by next arm.
        gen_random('h2400, 1'b1, 5, 1'b0, s);
        s[find_trig(s, 'h2400, 1'b1, 5) + 3] |= 16384;
        capture('h2400, 1'b1, 5, s, 1'b1, 1'b0);
        gen_random('h1800, 1'b0, 2, 1'b0, s);
        capture('h1800, 1'b0, 2, s, 1'b0, 1'b0);

        // Reset during POST, then a normal capture.
        gen_random('h3000, 1'b1, 3, 1'b0, s);
        s[1] |= 16384;
        capture('h3000, 1'b1, 3, s, 1'b0, 1'b1);
        gen_random('h3000, 1'b1, 3, 1'b1, s);
        capture('h3000, 1'b1, 3, s, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            lvl = int'($urandom_range('h100, 'h3E00));
            rising = 1'($urandom_range(0, 1));
            pre = int'($urandom_range(0, DEPTH - 1));
            gen_random(lvl, rising, pre, 1'b1, s);
            capture(lvl, rising, pre, s, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Constant input below level never crosses.
`ifdef AD_TRIG_TIMEOUT_EN
        begin
            int n;
            n = 0;
            do_arm('h2000, 1'b1, 0, 1'b0);
            ad_vld = 1'b1; ad_data = 'h1000;
            while (!done && n < 400) begin tick(); n++; end
            ad_vld = 1'b0;
            check("timeout_done", done, 1);
            check("timeout_trig_forced", trig_forced, 1);
            check("timeout_latency", (n >= TIMEOUT_CYC + DEPTH - 1) && (n <= TIMEOUT_CYC + DEPTH + 1), 1);
            for (int i = 0; i < DEPTH; i++) begin
                exp_t e;
                e.d = 'h1000;
                e.last = (i == DEPTH - 1);
                sb_q.push_back(e);
            end
            do_read();
        end
`else
        do_arm('h2000, 1'b1, 0, 1'b0);
        ad_vld = 1'b1; ad_data = 'h1000;
        repeat (150) tick();
        ad_vld = 1'b0;
        check("no_timeout_busy", busy, 1);
        check("no_timeout_done", done, 0);
        check("no_timeout_forced", trig_forced, 0);
        do_reset();
        check("idle_after_reset", busy, 0);
`endif

        repeat (4) tick();
        check("scoreboard_empty_at_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
